// File: rtl/fifo_stream_reader.sv
// Read-side adapter that turns the FIFO's 1-cycle-latency DEQ/DOUT port into a valid/ready stream.
// Optional transfer counter (CNT port) is built only when FIFO_READER_CNT_EN is defined.
module fifo_stream_reader #(
    parameter int WIDTH = 32
`ifdef FIFO_READER_CNT_EN
    ,
    parameter int W_CNT = 16
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             F_EMPTY,
    input  logic [WIDTH-1:0] F_DOUT,
    output logic             F_DEQ,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    input  logic             O_READY
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [W_CNT-1:0] CNT
`endif
);

    typedef logic [1:0] ptr_t;

    logic [WIDTH-1:0] skid_buf [0:2];
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    logic [1:0]       occ;
    logic             inflight;
    logic             capture;
    logic             transfer;
    logic [2:0]       pending;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one still on its way from the FIFO;
    // dequeuing only while this is below 3 guarantees a free slot on arrival.
    assign pending  = {1'b0, occ} + {2'b0, inflight};
    assign F_DEQ    = !RST && !F_EMPTY && (pending < 3'd3);
    assign capture  = inflight;
    assign O_VALID  = (occ != 2'd0);
    assign transfer = O_VALID && O_READY;

    always_comb begin
        O_DATA = skid_buf[0];
        case (rd_ptr)
            2'd1:    O_DATA = skid_buf[1];
            2'd2:    O_DATA = skid_buf[2];
            default: O_DATA = skid_buf[0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                skid_buf[i] <= '0;
            end
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= F_DEQ;
            if (capture) begin
                for (int i = 0; i < 3; i++) begin
                    if (wr_ptr == ptr_t'(i)) begin
                        skid_buf[i] <= F_DOUT;
                    end
                end
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (transfer) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({capture, transfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    occ_bound : assert property (@(posedge CLK) disable iff (RST) pending <= 3'd3);

`ifdef FIFO_READER_CNT_EN
    logic [W_CNT-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (transfer) begin
            cnt_q <= cnt_q + W_CNT'(1);
        end
    end

    assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed testbench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO in front of it.
// Define FIFO_READER_CNT_EN to also check the transfer counter.
module tb_fifo_stream_reader;

    localparam int WIDTH = 32;
`ifdef FIFO_READER_CNT_EN
    localparam int W_CNT = 16;
    logic [W_CNT-1:0] cnt;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             f_empty;
    logic [WIDTH-1:0] f_dout = '0;
    logic             f_deq;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_ready = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int xfer_total   = 0;

    logic [WIDTH-1:0] got [$];
    int               stamp [$];

    logic [WIDTH-1:0] fifo_mem [0:255];
    int               head = 0;
    int               tail = 0;

    fifo_stream_reader dut (
        .CLK     (clk),
        .RST     (rst),
        .F_EMPTY (f_empty),
        .F_DOUT  (f_dout),
        .F_DEQ   (f_deq),
        .O_DATA  (o_data),
        .O_VALID (o_valid),
        .O_READY (o_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .CNT     (cnt)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: DOUT is valid the cycle after DEQ, zero otherwise; reset flushes it.
    assign f_empty = (head == tail);

    always @(posedge clk) begin
        if (rst) begin
            head   <= tail;
            f_dout <= '0;
        end else if (f_deq) begin
            f_dout <= fifo_mem[head[7:0]];
            head   <= head + 1;
        end else begin
            f_dout <= '0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            xfer_total = 0;
        end else if (o_valid && o_ready) begin
            got.push_back(o_data);
            stamp.push_back(cyc);
            xfer_total = xfer_total + 1;
        end
    end

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_mem[tail[7:0]] = w;
        tail = tail + 1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        o_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push(32'hA0 + i);
            #1;
            n_compared++;
            if (f_deq !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_f_deq[%0d]: got %b expected 0 (f_empty=%b)", i, f_deq, f_empty);
            end
            n_compared++;
            if (o_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_o_valid[%0d]: got %b expected 0", i, o_valid);
            end
            n_compared++;
            if (o_data !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_o_data[%0d]: got %0h expected 0", i, o_data);
            end
        end
    endtask

    task automatic test_latency;
        @(posedge clk);
        @(negedge clk);
        got.delete();
        push(32'd7);
        rst     = 1'b0;
        o_ready = 1'b1;
        #1;
        n_compared++;
        if (f_deq !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL latency_deq_c0: got %b expected 1", f_deq);
        end
        @(negedge clk);
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL latency_valid_c1: got %b expected 0", o_valid);
        end
        @(negedge clk);
        n_compared++;
        if (o_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL latency_valid_c2: got %b expected 1", o_valid);
        end
        n_compared++;
        if (o_data !== 32'd7) begin
            n_mismatched++;
            $display("[TB] FAIL latency_data_c2: got %0h expected 7", o_data);
        end
        @(negedge clk);
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL latency_valid_c3: got %b expected 0", o_valid);
        end
        n_compared++;
        if (got.size() != 1 || got[0] !== 32'd7) begin
            n_mismatched++;
            $display("[TB] FAIL latency_count: got %0d transfers expected 1 of value 7", got.size());
        end
    endtask

    task automatic test_streaming;
        got.delete();
        stamp.delete();
        o_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            push(32'(i));
        end
        for (int c = 0; c < 100 && got.size() < 20; c++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (got.size() != 20) begin
            n_mismatched++;
            $display("[TB] FAIL stream_count: got %0d expected 20", got.size());
        end
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            n_compared++;
            if (got[i] !== 32'(i) || stamp[i] - stamp[0] != i) begin
                n_mismatched++;
                $display("[TB] FAIL stream_word[%0d]: got %0h at +%0d expected %0h at +%0d",
                         i, got[i], stamp[i] - stamp[0], i, i);
            end
        end
    endtask

    task automatic test_backpressure;
        got.delete();
        o_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            push(32'h100 + i);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_compared++;
                if (o_data !== 32'h100 || o_valid !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL bp_hold[%0d]: got %0h/%b expected 100/1", c, o_data, o_valid);
                end
            end
        end
        n_compared++;
        if (dut.occ !== 2'd3 || dut.inflight !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_occ: got occ=%0d inflight=%b expected 3/0", dut.occ, dut.inflight);
        end
        n_compared++;
        if (f_deq !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_deq: got %b expected 0", f_deq);
        end
        n_compared++;
        if (got.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_no_xfer: got %0d expected 0", got.size());
        end
        o_ready = 1'b1;
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (got.size() != 10) begin
            n_mismatched++;
            $display("[TB] FAIL bp_count: got %0d expected 10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_compared++;
            if (got[i] !== 32'h100 + i) begin
                n_mismatched++;
                $display("[TB] FAIL bp_word[%0d]: got %0h expected %0h", i, got[i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_toggle_ready;
        got.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            push(32'd200 + i);
            o_ready = (i % 2 == 0);
        end
        @(negedge clk);
        o_ready = 1'b1;
        for (int c = 0; c < 200 && got.size() < 30; c++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (got.size() != 30) begin
            n_mismatched++;
            $display("[TB] FAIL toggle_count: got %0d expected 30", got.size());
        end
        for (int i = 0; i < 30 && i < got.size(); i++) begin
            n_compared++;
            if (got[i] !== 32'd200 + i) begin
                n_mismatched++;
                $display("[TB] FAIL toggle_word[%0d]: got %0d expected %0d", i, got[i], 200 + i);
            end
        end
`ifdef FIFO_READER_CNT_EN
        n_compared++;
        if (cnt !== W_CNT'(xfer_total)) begin
            n_mismatched++;
            $display("[TB] FAIL toggle_cnt: got %0d expected %0d", cnt, xfer_total);
        end
`endif
    endtask

    task automatic test_mid_reset;
        got.delete();
        o_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push(32'd300 + i);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (dut.occ !== 2'd2 || dut.inflight !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mid_pre_state: got occ=%0d inflight=%b expected 2/1", dut.occ, dut.inflight);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_compared++;
        if (o_valid !== 1'b0 || dut.occ !== 2'd0 || dut.inflight !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_post_state: got valid=%b occ=%0d inflight=%b expected 0/0/0",
                     o_valid, dut.occ, dut.inflight);
        end
`ifdef FIFO_READER_CNT_EN
        n_compared++;
        if (cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_cnt: got %0d expected 0", cnt);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            push(32'd400 + i);
        end
        o_ready = 1'b1;
        for (int c = 0; c < 100 && got.size() < 3; c++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (got.size() != 3) begin
            n_mismatched++;
            $display("[TB] FAIL mid_count: got %0d expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_compared++;
            if (got[i] !== 32'd400 + i) begin
                n_mismatched++;
                $display("[TB] FAIL mid_word[%0d]: got %0d expected %0d", i, got[i], 400 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_toggle_ready();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
